// File: rtl/glb_psum_drain_pkg.sv
// glb_psum_drain_pkg: GLB geometry, bank IDs and drain FSM state encoding shared with TOP_ctrl and GLB.
package glb_psum_drain_pkg;
  function automatic int clogb2(input int value);
    int bits;
    bits = 0;
    for (int v = value; v > 0; v = v >> 1) bits++;
    return (bits == 0) ? 1 : bits;
  endfunction
  localparam int BANK_IFMAP = 0;
  localparam int BANK_PSUM = 1;
  localparam int BANK_WGHT = 2;
  localparam int GLB_DATA_BITWIDTH = 32;
  localparam int GLB_BANK_NUM = 3;
  localparam int GLB_BANK_DEPTH = 8192;
  localparam int GLB_AW = clogb2(GLB_BANK_DEPTH - 1);
  localparam int GLB_CW = GLB_AW + 1;
  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} drain_state_e;
endpackage

// File: rtl/psum_drain_fifo.sv
// psum_drain_fifo: 2-entry synchronous FIFO buffering GLB read data ahead of the output stream.
module psum_drain_fifo #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);
  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_push;
  logic         do_pop;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];
  assign full    = count == 2'd2;
  assign empty   = count == 2'd0;
  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end
endmodule

// File: rtl/glb_psum_drain.sv
// glb_psum_drain: reads finished psums from the GLB psum bank and streams them out over valid/ready.
module glb_psum_drain
  import glb_psum_drain_pkg::*;
#(
  parameter int DATA_BITWIDTH = GLB_DATA_BITWIDTH,
  parameter int BANK_NUM      = GLB_BANK_NUM,
  parameter int BANK_DEPTH    = GLB_BANK_DEPTH,
  parameter int PSUM_BANK_ID  = BANK_PSUM,
  parameter int AW            = clogb2(BANK_DEPTH - 1),
  parameter int CW            = AW + 1,
  parameter int BW            = clogb2(BANK_NUM - 1)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic [AW-1:0]            i_base_addr,
  input  logic [CW-1:0]            i_word_count,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_glb_req,
  output logic [BW-1:0]            o_glb_bank_sel,
  output logic                     o_glb_re,
  output logic [AW-1:0]            o_glb_ra,
  input  logic [DATA_BITWIDTH-1:0] i_glb_rd,
  output logic [DATA_BITWIDTH-1:0] o_data,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic                     o_last
);
  drain_state_e state_q, state_d;
  logic [AW-1:0] base_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] issued_q;
  logic [CW-1:0] accepted_q;
  logic          inflight_q;
  logic          re;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [1:0]    fifo_count;
  logic [2:0]    credit_used;
  logic          start_ok;
  psum_drain_fifo #(.W(DATA_BITWIDTH)) u_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .push  (inflight_q),
    .din   (i_glb_rd),
    .pop   (pop),
    .head  (o_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );
  assign o_valid        = ~fifo_empty;
  assign pop            = o_valid & i_ready;
  assign o_last         = o_valid & (accepted_q == count_q - CW'(1));
  assign o_busy         = (state_q == S_READ) || (state_q == S_DRAIN);
  assign o_glb_req      = o_busy;
  assign o_done         = state_q == S_DONE;
  assign o_glb_bank_sel = BW'(PSUM_BANK_ID);
  assign o_glb_ra       = base_q + issued_q[AW-1:0];
  assign o_glb_re       = re;
  assign start_ok       = (state_q == S_IDLE) && i_start;
  // A same-cycle pop frees its slot, which keeps one read per cycle under full throughput.
  assign credit_used    = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
  always_comb begin
    state_d = state_q;
    re      = 1'b0;
    case (state_q)
      S_IDLE:  if (i_start) state_d = (i_word_count == '0) ? S_DONE : S_READ;
      S_READ: begin
        re = (issued_q != count_q) && (credit_used < 3'd2) && !(fifo_full && !pop);
        if (issued_q == count_q) state_d = S_DRAIN;
      end
      S_DRAIN: if (accepted_q + CW'(pop) == count_q) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      count_q    <= '0;
      issued_q   <= '0;
      accepted_q <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= re;
      if (start_ok) begin
        base_q     <= i_base_addr;
        count_q    <= i_word_count;
        issued_q   <= '0;
        accepted_q <= '0;
      end else begin
        issued_q   <= issued_q + CW'(re);
        accepted_q <= accepted_q + CW'(pop);
      end
    end
  end
endmodule

// File: tb/tb_glb_psum_drain.sv
// tb_glb_psum_drain: directed drains checked every cycle against a queue-based model of the drain rules.
module tb_glb_psum_drain;
  localparam int DW = 32;
  localparam int AW = 13;
  localparam int CW = 14;
  localparam int DEPTH = 8192;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic ready = 1'b1;
  logic [AW-1:0] base_addr = '0;
  logic [CW-1:0] word_count = '0;
  logic [DW-1:0] glb_rd;
  logic busy, done, glb_req, glb_re, valid, last;
  logic [1:0] bank_sel;
  logic [AW-1:0] glb_ra;
  logic [DW-1:0] data;
  logic [DW-1:0] mem [DEPTH];
  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  bit m_busy = 0;
  bit m_done = 0;
  int m_base = 0, m_count = 0, m_issued = 0, m_acc = 0;
  logic [31:0] q_data[$];
  int q_rdy[$];
  int re_log[$], re_cyc[$], hs_cyc[$], done_cyc[$];
  logic [31:0] hs_log[$];
  bit hs_last[$];
  always #5 clk = ~clk;
  glb_psum_drain dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_base_addr(base_addr), .i_word_count(word_count),
    .o_busy(busy), .o_done(done), .o_glb_req(glb_req), .o_glb_bank_sel(bank_sel),
    .o_glb_re(glb_re), .o_glb_ra(glb_ra), .i_glb_rd(glb_rd),
    .o_data(data), .o_valid(valid), .i_ready(ready), .o_last(last)
  );
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (glb_re) glb_rd <= mem[glb_ra];
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask
  // Model: a word becomes visible two cycles after its read; reads are owed while fewer than two words are outstanding.
  always @(negedge clk) begin
    bit ev, er, pp, fin;
    int addr;
    ev = q_data.size() > 0 && q_rdy[0] <= cyc;
    pp = ev && ready;
    er = m_busy && m_issued < m_count && (m_issued - m_acc - int'(pp)) < 2;
    addr = (m_base + m_issued) % DEPTH;
    chk("busy", busy, m_busy);
    chk("glb_req", glb_req, m_busy);
    chk("done", done, m_done);
    chk("bank_sel", bank_sel, 1);
    chk("glb_re", glb_re, er);
    if (er) chk("glb_ra", glb_ra, addr);
    chk("valid", valid, ev);
    chk("last", last, ev && m_acc == m_count - 1);
    if (ev) chk("data", data, q_data[0]);
    if (glb_re) begin re_log.push_back(int'(glb_ra)); re_cyc.push_back(cyc); end
    if (valid && ready) begin hs_log.push_back(data); hs_cyc.push_back(cyc); hs_last.push_back(last); end
    if (done) done_cyc.push_back(cyc);
    fin = pp && (m_acc + 1 == m_count);
    if (rst) begin
      m_busy = 0; m_done = 0; m_issued = 0; m_acc = 0; m_count = 0;
      q_data.delete(); q_rdy.delete();
    end else begin
      if (er) begin q_data.push_back(mem[addr]); q_rdy.push_back(cyc + 2); m_issued++; end
      if (pp) begin void'(q_data.pop_front()); void'(q_rdy.pop_front()); m_acc++; end
      if (start && !m_busy && !m_done) begin
        m_base = int'(base_addr); m_count = int'(word_count); m_issued = 0; m_acc = 0;
        m_busy = word_count != 0; m_done = word_count == 0;
      end else begin
        m_done = fin;
        if (fin) m_busy = 0;
      end
    end
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic do_start(input int b, input int c);
    start = 1'b1; base_addr = AW'(b); word_count = CW'(c);
    tick(1);
    start = 1'b0;
  endtask
  task automatic clear_logs();
    re_log.delete(); re_cyc.delete(); hs_log.delete(); hs_cyc.delete(); hs_last.delete(); done_cyc.delete();
  endtask
  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 200) begin tick(1); n++; end
    chk({name, "_done_seen"}, done, 1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int s, n;
    logic [31:0] wrap_exp [4];
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h1000_0000 + i;
    for (int i = 0; i < 4; i++) mem[100 + i] = 32'hA0 + i;
    mem[8190] = 32'hC0DE_0000; mem[8191] = 32'hC0DE_0001; mem[0] = 32'hC0DE_0002; mem[1] = 32'hC0DE_0003;
    wrap_exp = '{32'hC0DE_0000, 32'hC0DE_0001, 32'hC0DE_0002, 32'hC0DE_0003};
    tick(3);
    chk("rst_busy", busy, 0); chk("rst_valid", valid, 0); chk("rst_ra", glb_ra, 0); chk("rst_data", data, 0);
    rst = 1'b0;
    tick(1);
    clear_logs(); s = cyc;
    do_start(100, 4);
    wait_done("basic"); tick(1);
    chk("basic_nre", re_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("basic_ra", re_log[i], 100 + i);
      chk("basic_re_cyc", re_cyc[i], s + 1 + i);
      chk("basic_data", hs_log[i], 32'hA0 + i);
      chk("basic_hs_cyc", hs_cyc[i], hs_cyc[0] + i);
      chk("basic_last", hs_last[i], i == 3);
    end
    chk("basic_done_cyc", done_cyc[0], hs_cyc[3] + 1);
    clear_logs();
    do_start(100, 4);
    for (int k = 1; k <= 8; k++) begin
      ready = !(k >= 4 && k <= 7);
      if (k >= 4 && k <= 7) begin chk("bp_hold_valid", valid, 1); chk("bp_hold_data", data, 32'hA1); end
      tick(1);
    end
    ready = 1'b1;
    wait_done("bp"); tick(1);
    chk("bp_nre", re_log.size(), 4);
    chk("bp_nhs", hs_log.size(), 4);
    for (int i = 0; i < 4; i++) chk("bp_data", hs_log[i], 32'hA0 + i);
    clear_logs();
    do_start(8190, 4);
    wait_done("wrap"); tick(1);
    chk("wrap_nhs", hs_log.size(), 4);
    chk("wrap_ra0", re_log[0], 8190); chk("wrap_ra1", re_log[1], 8191);
    chk("wrap_ra2", re_log[2], 0); chk("wrap_ra3", re_log[3], 1);
    for (int i = 0; i < 4; i++) chk("wrap_data", hs_log[i], wrap_exp[i]);
    clear_logs();
    do_start(5, 0);
    chk("zero_done", done, 1); chk("zero_busy", busy, 0);
    tick(3);
    chk("zero_nre", re_log.size(), 0); chk("zero_nhs", hs_log.size(), 0); chk("zero_ndone", done_cyc.size(), 1);
    clear_logs();
    do_start(200, 16);
    n = 0;
    while (hs_log.size() < 5 && n < 100) begin tick(1); n++; end
    chk("rst_progress", hs_log.size() >= 5, 1);
    rst = 1'b1; tick(1); rst = 1'b0;
    chk("mid_busy", busy, 0); chk("mid_done", done, 0); chk("mid_req", glb_req, 0); chk("mid_re", glb_re, 0);
    chk("mid_valid", valid, 0); chk("mid_last", last, 0); chk("mid_ra", glb_ra, 0); chk("mid_data", data, 0);
    clear_logs(); tick(3);
    chk("mid_no_done", done_cyc.size(), 0);
    do_start(0, 2);
    wait_done("after_rst"); tick(1);
    chk("after_rst_nhs", hs_log.size(), 2);
    chk("after_rst_d0", hs_log[0], 32'hC0DE_0002); chk("after_rst_d1", hs_log[1], 32'hC0DE_0003);
    clear_logs();
    do_start(300, 4);
    do_start(500, 3);
    wait_done("busy_start"); tick(3);
    chk("busy_start_nre", re_log.size(), 4);
    chk("busy_start_nhs", hs_log.size(), 4);
    chk("busy_start_ndone", done_cyc.size(), 1);
    for (int i = 0; i < 4; i++) begin
      chk("busy_start_ra", re_log[i], 300 + i);
      chk("busy_start_data", hs_log[i], 32'h1000_012C + i);
    end
    tick(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
